alu_control_pipe: RTL and testbench
===================================

# alu_control_pipe

Registered, parametrised ALU-control stage at the ID/EX boundary of the pipelined MIPS datapath. It decodes ALUOp/Funct/Op into the ALU control code, holds that code in a pipeline register with valid, stall and flush handling, and sequences a multi-cycle multiply. While a multiply runs, the block holds the ID stage and reports the busy window. It replaces the purely combinational ALU-control decode in the EX path.

## Interface
- ALUCTL_W, 6: ALU control output width; must be ≥ 6; bits above [5:0] are always zero.
- MUL_CYCLES, 4: EX occupancy of MUL in cycles; must be ≥ 1; a value of 1 makes MUL single-cycle.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- ALUOp  in  2  class from main control: 00 R-type, 01 I-type/branch, 10 jump, 11 reserved.
- Funct  in  6  instruction [5:0].
- Op  in  6  instruction [31:26].
- InValid  in  1  ID holds a valid instruction.
- StallIn  in  1  downstream freeze; hold all state.
- Flush  in  1  kill ID/EX contents.
- ALUControl  out  ALUCTL_W  registered ALU control code.
- OutValid  out  1  ALUControl is valid for EX.
- MulBusy  out  1  a multiply occupies EX and its result is not final.
- StallOut  out  1  ID/IF must hold their contents.
- Illegal  out  1  sticky unknown-encoding flag.

## Operation
- **Decode, R-type (ALUOp = 00):** the code equals Funct for ADD 100000, SUB 100010, MUL 011000, AND 100100, OR 100101, NOR 100111, XOR 100110, SLL 000000, SRL 000010, SLT 101010 and JR 001000.
- **Decode, ALUOp = 01, address/ALU ops:**
  - Op 101011, 100011, 001000, 101000, 100000, 101001, 100001 → 100000.
  - ANDI → 100100; ORI → 100101; XORI → 100110; SLTI → 101010.
- **Decode, ALUOp = 01, branches:** Op 000001, 000100, 000101, 000111, 000110 → code equals Op.
- **Decode, jumps (ALUOp = 10):** J → 000010; JAL → 000011.
- **Unknown encodings:** any encoding not listed above, including ALUOp = 11, is unknown; see Configuration.
- **States:** IDLE and MUL_BUSY, with a down-counter of width $clog2(MUL_CYCLES)+1.
- **Update precedence** (highest first):
  1. Flush: ALUControl ← 000000 (NOP), OutValid ← 0, state ← IDLE, counter ← 0.
  2. StallIn: all registers hold.
  3. State update, below.
- **IDLE:** the register loads the decoded code and OutValid ← InValid.
  - If the loaded code is MUL, InValid = 1 and MUL_CYCLES > 1: state ← MUL_BUSY and counter ← MUL_CYCLES−1.
- **MUL_BUSY:** ALUControl and OutValid hold. Each cycle the counter decrements.
  - When the counter decrements from 1 to 0, state ← IDLE.
  - Inputs presented during MUL_BUSY are not captured; StallOut keeps them stable upstream.
- **Combinational outputs:** MulBusy = StallOut = (state == MUL_BUSY).

## Timing
- **Reset values:** ALUControl = 0, OutValid = 0, MulBusy = 0, StallOut = 0, Illegal = 0, state = IDLE, counter = 0. Reset is asynchronous on assertion and synchronous on release.
- **Latency:** 1 cycle from inputs to ALUControl.
- **MUL occupancy:** a MUL occupies the register for MUL_CYCLES unstalled cycles, and StallOut is high for MUL_CYCLES−1 of them. The instruction following MUL loads on the first edge after StallOut falls.
- **StallIn during MUL_BUSY:** freezes the counter; the busy window extends cycle-for-cycle.
- **Flush and StallIn in the same cycle:** Flush wins.
- **Flush during MUL_BUSY:** aborts the multiply; StallOut drops in the next cycle.
- **Back-to-back MULs:** each one takes a full busy window; there is no overlap.

## Configuration
- **ALUCTL_ILLEGAL_TRAP_EN defined:**
  - An unknown encoding with InValid = 1, accepted in IDLE, loads NOP with OutValid = 0.
  - It sets Illegal, which stays high until reset. Flush does not clear it.
- **ALUCTL_ILLEGAL_TRAP_EN undefined:**
  - An unknown encoding loads NOP with OutValid = InValid.
  - Illegal is tied to 0.

## Test plan
- **Reset mid-MUL:** release reset, load MUL (ALUOp = 00, Funct = 011000) with MUL_CYCLES = 4, then assert Rst_n = 0 in the second busy cycle. Require all outputs to reach 0 immediately, without waiting for a clock edge.
- **MUL window:** MUL followed by ADD, MUL_CYCLES = 4. Require ALUControl = 011000 for 4 cycles, StallOut high for 3 cycles, then ALUControl = 100000 on the next edge.
- **StallIn during MUL:** MUL with StallIn high for 2 cycles in MUL_BUSY. Require StallOut high for 5 cycles in total and the counter frozen while StallIn is high.
- **Flush precedence:** Flush and StallIn asserted together while ADD is held. Require ALUControl = 000000 and OutValid = 0 on the next edge.
- **Decode sweep:** LW, ORI, BNE and JAL each with InValid = 1. Require codes 100000, 100101, 000101 and 000011, each after 1 cycle of latency.
- **Illegal encoding:** ALUOp = 11 with InValid = 1.
  - With ALUCTL_ILLEGAL_TRAP_EN defined: Illegal = 1, staying high through a subsequent Flush, and OutValid = 0.
  - With the macro undefined: Illegal = 0, OutValid = 1 and ALUControl = 000000.

Source files
------------

// File: rtl/alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_pipe
// Purpose  : Registered ALU-control stage at the ID/EX boundary of a
//            pipelined MIPS datapath.
//            - Decodes ALUOp/Funct/Op into a 6-bit ALU control code.
//            - Holds the code in a pipeline register with valid, stall and
//              flush handling.
//            - Sequences a multi-cycle multiply, holding ID/IF while it runs.
// Params   : ALUCTL_W   - ALU control output width (>= 6, upper bits zero)
//            MUL_CYCLES - EX occupancy of MUL in cycles (>= 1)
// Ports    : Clk        in   rising-edge clock
//            Rst_n      in   asynchronous active-low reset
//            ALUOp      in   [1:0] class from main control
//            Funct      in   [5:0] instruction[5:0]
//            Op         in   [5:0] instruction[31:26]
//            InValid    in   ID holds a valid instruction
//            StallIn    in   downstream freeze, hold all state
//            Flush      in   kill ID/EX contents
//            ALUControl out  [ALUCTL_W-1:0] registered ALU control code
//            OutValid   out  ALUControl is valid for EX
//            MulBusy    out  multiply occupies EX, result not final
//            StallOut   out  ID/IF must hold their contents
//            Illegal    out  sticky unknown-encoding flag
// Macro    : ALUCTL_ILLEGAL_TRAP_EN - when defined, unknown encodings load an
//            invalid NOP and set the sticky Illegal flag; when undefined,
//            they load a NOP carrying InValid and Illegal stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_pipe #(
  parameter int ALUCTL_W   = 6,
  parameter int MUL_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [1:0]          ALUOp,
  input  logic [5:0]          Funct,
  input  logic [5:0]          Op,
  input  logic                InValid,
  input  logic                StallIn,
  input  logic                Flush,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                OutValid,
  output logic                MulBusy,
  output logic                StallOut,
  output logic                Illegal
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [5:0] CODE_NOP = 6'b000000;
  localparam logic [5:0] CODE_MUL = 6'b011000;

`ifdef ALUCTL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [5:0]       code, code_nx;
  logic             valid, valid_nx;
  logic             illegal_flag, illegal_nx;

  logic [5:0]       dec_code;
  logic             dec_unknown;

  // Decode; unknown encodings produce the NOP code.
  always_comb begin
    dec_code    = CODE_NOP;
    dec_unknown = 1'b0;
    case (ALUOp)
      2'b00: begin
        case (Funct)
          6'b100000, 6'b100010, 6'b011000, 6'b100100, 6'b100101,
          6'b100111, 6'b100110, 6'b000000, 6'b000010, 6'b101010,
          6'b001000: dec_code = Funct;
          default:   dec_unknown = 1'b1;
        endcase
      end
      2'b01: begin
        case (Op)
          6'b101011, 6'b100011, 6'b001000, 6'b101000, 6'b100000,
          6'b101001, 6'b100001: dec_code = 6'b100000;
          6'b001100: dec_code = 6'b100100;   // ANDI
          6'b001101: dec_code = 6'b100101;   // ORI
          6'b001110: dec_code = 6'b100110;   // XORI
          6'b001010: dec_code = 6'b101010;   // SLTI
          6'b000001, 6'b000100, 6'b000101, 6'b000111,
          6'b000110: dec_code = Op;          // branches pass the opcode
          default:   dec_unknown = 1'b1;
        endcase
      end
      2'b10: begin
        case (Op)
          6'b000010: dec_code = 6'b000010;   // J
          6'b000011: dec_code = 6'b000011;   // JAL
          default:   dec_unknown = 1'b1;
        endcase
      end
      default: dec_unknown = 1'b1;
    endcase
  end

  // Next-state logic: Flush beats StallIn beats the normal state update.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    code_nx    = code;
    valid_nx   = valid;
    illegal_nx = illegal_flag;
    if (Flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      code_nx  = CODE_NOP;
      valid_nx = 1'b0;
    end else if (!StallIn) begin
      case (state)
        IDLE: begin
          code_nx  = dec_code;
          valid_nx = InValid && !(TRAP_EN && dec_unknown);
          if (TRAP_EN && dec_unknown && InValid) begin
            illegal_nx = 1'b1;
          end
          // A single-cycle MUL never enters the busy state.
          if ((dec_code == CODE_MUL) && InValid && (MUL_CYCLES > 1)) begin
            state_nx = MUL_BUSY;
            cnt_nx   = CNT_LOAD;
          end
        end
        MUL_BUSY: begin
          cnt_nx = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      code         <= CODE_NOP;
      valid        <= 1'b0;
      illegal_flag <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      code         <= code_nx;
      valid        <= valid_nx;
      illegal_flag <= illegal_nx;
    end
  end

  assign ALUControl = ALUCTL_W'(code);
  assign OutValid   = valid;
  assign MulBusy    = (state == MUL_BUSY);
  assign StallOut   = (state == MUL_BUSY);
  assign Illegal    = illegal_flag;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_pipe
// Purpose  : Self-checking bench for alu_control_pipe (ALUCTL_W=6,
//            MUL_CYCLES=4): table-driven decode vectors plus directed
//            sequences for reset, multiply window, stalls, flush and the
//            illegal-encoding flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_pipe;

  localparam int W = 6;

`ifdef ALUCTL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [1:0]   ALUOp;
  logic [5:0]   Funct;
  logic [5:0]   Op;
  logic         InValid;
  logic         StallIn;
  logic         Flush;
  logic [W-1:0] ALUControl;
  logic         OutValid;
  logic         MulBusy;
  logic         StallOut;
  logic         Illegal;

  int compared = 0;
  int mismatched = 0;

  alu_control_pipe #(.ALUCTL_W(W), .MUL_CYCLES(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ALUOp(ALUOp), .Funct(Funct), .Op(Op),
    .InValid(InValid), .StallIn(StallIn), .Flush(Flush),
    .ALUControl(ALUControl), .OutValid(OutValid), .MulBusy(MulBusy),
    .StallOut(StallOut), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [5:0] op;
    logic       inv;
    logic       bad;      // encoding is unknown
    logic [5:0] code;     // expected ALUControl
    logic       valid;    // expected OutValid with the trap disabled
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [5:0] f, input logic [5:0] o, input logic v);
    ALUOp = a; Funct = f; Op = o; InValid = v;
  endtask

  logic exp_ill;
  logic exp_v;
  int   high_cnt;

  initial begin
    vecs[0]  = '{2'b00, 6'b100000, 6'd0, 1'b1, 1'b0, 6'b100000, 1'b1}; // ADD
    vecs[1]  = '{2'b00, 6'b100010, 6'd0, 1'b1, 1'b0, 6'b100010, 1'b1}; // SUB
    vecs[2]  = '{2'b00, 6'b001000, 6'd0, 1'b1, 1'b0, 6'b001000, 1'b1}; // JR
    vecs[3]  = '{2'b01, 6'd0, 6'b100011, 1'b1, 1'b0, 6'b100000, 1'b1}; // LW
    vecs[4]  = '{2'b01, 6'd0, 6'b001101, 1'b1, 1'b0, 6'b100101, 1'b1}; // ORI
    vecs[5]  = '{2'b01, 6'd0, 6'b001010, 1'b1, 1'b0, 6'b101010, 1'b1}; // SLTI
    vecs[6]  = '{2'b01, 6'd0, 6'b000101, 1'b1, 1'b0, 6'b000101, 1'b1}; // BNE
    vecs[7]  = '{2'b01, 6'd0, 6'b000111, 1'b1, 1'b0, 6'b000111, 1'b1}; // BGTZ
    vecs[8]  = '{2'b10, 6'd0, 6'b000011, 1'b1, 1'b0, 6'b000011, 1'b1}; // JAL
    vecs[9]  = '{2'b10, 6'd0, 6'b000010, 1'b1, 1'b0, 6'b000010, 1'b1}; // J
    vecs[10] = '{2'b00, 6'b100000, 6'd0, 1'b0, 1'b0, 6'b100000, 1'b0}; // ADD, not valid
    vecs[11] = '{2'b00, 6'b011000, 6'd0, 1'b0, 1'b0, 6'b011000, 1'b0}; // MUL, not valid: no busy
    vecs[12] = '{2'b00, 6'b111111, 6'd0, 1'b1, 1'b1, 6'b000000, 1'b1}; // unknown funct
    vecs[13] = '{2'b01, 6'd0, 6'b111111, 1'b1, 1'b1, 6'b000000, 1'b1}; // unknown opcode

    // ---- reset state ----
    Rst_n = 1'b0; StallIn = 1'b0; Flush = 1'b0;
    drive(2'b00, 6'd0, 6'd0, 1'b0);
    step(); step();
    check("reset_code", 32'(ALUControl), 32'd0);
    check("reset_valid", 32'(OutValid), 32'd0);
    check("reset_busy", 32'({MulBusy, StallOut, Illegal}), 32'd0);
    Rst_n = 1'b1;
    step();

    // ---- decode table ----
    exp_ill = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].aluop, vecs[i].funct, vecs[i].op, vecs[i].inv);
      step();
      exp_v = vecs[i].valid;
      if (TRAP && vecs[i].bad && vecs[i].inv) begin
        exp_v = 1'b0;
        exp_ill = 1'b1;
      end
      check($sformatf("vec%0d_code", i), 32'(ALUControl), 32'(vecs[i].code));
      check($sformatf("vec%0d_valid", i), 32'(OutValid), 32'(exp_v));
      check($sformatf("vec%0d_stallout", i), 32'(StallOut), 32'd0);
      check($sformatf("vec%0d_illegal", i), 32'(Illegal), 32'(exp_ill));
    end

    // Fresh start for the sequences.
    Rst_n = 1'b0; drive(2'b00, 6'd0, 6'd0, 1'b0); step(); Rst_n = 1'b1; step();

    // ---- MUL window: MUL then ADD ----
    drive(2'b00, 6'b011000, 6'd0, 1'b1);
    step();
    drive(2'b00, 6'b100000, 6'd0, 1'b1);
    high_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mulwin_code%0d", c), 32'(ALUControl), 32'h18);
      check($sformatf("mulwin_valid%0d", c), 32'(OutValid), 32'd1);
      check($sformatf("mulwin_busyeq%0d", c), 32'(MulBusy), 32'(StallOut));
      if (StallOut) high_cnt++;
      step();
    end
    check("mulwin_stall_cycles", 32'(high_cnt), 32'd3);
    check("mulwin_next_add", 32'(ALUControl), 32'h20);
    check("mulwin_idle", 32'(StallOut), 32'd0);

    // ---- StallIn during MUL ----
    drive(2'b00, 6'b011000, 6'd0, 1'b1);
    step();
    drive(2'b00, 6'b100100, 6'd0, 1'b1);  // AND waits behind the MUL
    high_cnt = StallOut ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      StallIn = (c < 2);
      step();
      if (!StallOut) break;
      high_cnt++;
      check($sformatf("mulstall_code%0d", c), 32'(ALUControl), 32'h18);
    end
    StallIn = 1'b0;
    check("mulstall_cycles", 32'(high_cnt), 32'd5);
    check("mulstall_still_mul", 32'(ALUControl), 32'h18);
    step();
    check("mulstall_next_and", 32'(ALUControl), 32'h24);

    // ---- StallIn alone holds, Flush beats StallIn ----
    drive(2'b00, 6'b100000, 6'd0, 1'b1);
    step();
    check("hold_add", 32'(ALUControl), 32'h20);
    drive(2'b00, 6'b100010, 6'd0, 1'b1);
    StallIn = 1'b1;
    step();
    check("stallin_holds", 32'(ALUControl), 32'h20);
    Flush = 1'b1;
    step();
    check("flush_code", 32'(ALUControl), 32'd0);
    check("flush_valid", 32'(OutValid), 32'd0);
    Flush = 1'b0; StallIn = 1'b0;

    // ---- Flush during MUL_BUSY ----
    drive(2'b00, 6'b011000, 6'd0, 1'b1);
    step();
    check("flushmul_busy", 32'(StallOut), 32'd1);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("flushmul_drop", 32'(StallOut), 32'd0);
    check("flushmul_code", 32'(ALUControl), 32'd0);

    // ---- Back-to-back MULs ----
    drive(2'b00, 6'b011000, 6'd0, 1'b1);
    step(); step(); step();
    check("b2b_first_busy", 32'(StallOut), 32'd1);
    step();
    check("b2b_gap", 32'(StallOut), 32'd0);
    step();
    check("b2b_second_busy", 32'(StallOut), 32'd1);
    check("b2b_second_code", 32'(ALUControl), 32'h18);
    drive(2'b00, 6'd0, 6'd0, 1'b0);
    step(); step(); step();
    check("b2b_done", 32'(StallOut), 32'd0);

    // ---- Reset mid-MUL (asynchronous) ----
    drive(2'b00, 6'b011000, 6'd0, 1'b1);
    step();
    drive(2'b00, 6'd0, 6'd0, 1'b0);
    step();
    check("rstmul_busy", 32'(StallOut), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("rstmul_code", 32'(ALUControl), 32'd0);
    check("rstmul_valid", 32'(OutValid), 32'd0);
    check("rstmul_flags", 32'({MulBusy, StallOut, Illegal}), 32'd0);
    step();
    Rst_n = 1'b1;
    step();

    // ---- Illegal encoding (ALUOp = 11) ----
    drive(2'b11, 6'b100000, 6'b000000, 1'b1);
    step();
    check("ill_code", 32'(ALUControl), 32'd0);
    check("ill_valid", 32'(OutValid), 32'(!TRAP));
    check("ill_flag", 32'(Illegal), 32'(TRAP));
    drive(2'b00, 6'd0, 6'd0, 1'b0);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("ill_after_flush", 32'(Illegal), 32'(TRAP));
    check("ill_flush_valid", 32'(OutValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
